mc_seq_ctrl: RTL and testbench
==============================

# mc_seq_ctrl

Multi-cycle sequencing controller for the 32-bit MIPS core. It replaces single-cycle issue with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a ready handshake. It sits beside the main opcode decoder: the decoder still drives ALU/extender/mux selects from `op`, and this block drives every write-enable, the PC source and the memory request.

## Interface
- `MEM_TIMEOUT`, 16: maximum wait cycles for `mem_ready` per access before bus error; legal range 1..65535.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op`  in  6  opcode field of the instruction register; valid from the ID state onward.
- `branch_taken`  in  1  ALU branch condition (BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ), valid in the BR state.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request; held until `mem_ready`.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ir_wr`  out  1  load instruction register.
- `pc_wr`  out  1  PC write enable.
- `pc_src`  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- `reg_wr`  out  1  register file write enable.
- `link`  out  1  JAL writeback: destination r31, data PC+4.
- `state`  out  4  current state encoding, for debug.
- `illegal`  out  1  one-cycle pulse on an undecodable opcode.
- `bus_err`  out  1  sticky memory timeout flag.
- `retired`  out  32  retired instruction count.

## Operation
- Opcode classes: R = 000000; ALUI = 001001, 001010, 001011, 001100, 001101, 001110, 001111; LOAD = 100011, 100000, 100100; STORE = 101011, 101000; BR = 000001, 000100, 000101, 000110, 000111; J = 000010; JAL = 000011; every other opcode is ILL.
- States: RST, IF, ID, EX, MADDR, MRD, MWR, WB, WBM, BR, JMP, HALT.
- RST → IF. IF waits for `mem_ready`, then → ID. ID → EX (R, ALUI), MADDR (LOAD, STORE), BR, JMP (J, JAL), or IF (ILL).
- EX → WB → IF. MADDR → MRD (LOAD) or MWR (STORE). MRD waits for ready → WBM → IF. MWR waits for ready → IF. BR → IF. JMP → IF.
- Outputs by state:
  - IF: `mem_req`=1, `iord`=0. On the ready cycle, `ir_wr`=1, `pc_wr`=1, `pc_src`=00.
  - MRD: `mem_req`=1, `iord`=1.
  - MWR: `mem_req`=1, `mem_we`=1, `iord`=1.
  - WB, WBM: `reg_wr`=1.
  - BR: `pc_wr`=`branch_taken`, `pc_src`=01.
  - JMP: `pc_wr`=1, `pc_src`=10. For JAL, additionally `reg_wr`=1 and `link`=1.
  - ID with ILL: `illegal`=1.
  - All other outputs are 0 in every state.
- Wait counter: cleared on entry to IF, MRD and MWR; increments on each cycle without `mem_ready`. If the counter reaches `MEM_TIMEOUT`, `mem_req` drops that same cycle, `bus_err` is set and the FSM goes to HALT. HALT is left only by reset.
- `retired` increments by 1 on leaving WB, WBM, BR or JMP, and on the ready cycle of MWR. It wraps modulo 2^32. ILL instructions do not count.
- `mem_ready` while `mem_req`=0 is ignored.

## Timing
- Reset (asserted): state = RST, every output 0, `retired` = 0, `bus_err` = 0, wait counter = 0. Reset mid-access drops `mem_req` asynchronously.
- First `mem_req` appears in the second cycle after `rst_n` rises (RST occupies one cycle).
- Minimum cycles per instruction, with zero-wait memory (ready in the first request cycle): R/ALUI 4, LOAD 5, STORE 4, BR 3, J/JAL 3, ILL 2. Each memory wait cycle adds 1.
- `ir_wr`, `pc_wr` (in IF) and the MRD/MWR completions are Mealy-qualified on `mem_ready`; everything else is a pure function of state.
- `branch_taken` is sampled combinationally in BR only.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encoding constants (4-bit);
  - opcode constants for every class above;
  - `pc_src` encodings;
  - an instruction-class enum {R, ALUI, LOAD, STORE, BR, J, JAL, ILL}.
- One sub-module, `op_classify`: combinational, `op` → class. It is reused by the main decoder's testbench.
- The FSM, wait counter and retire counter live in the top module.

## Test plan
- Reset release with `mem_ready`=1 and an ADDIU (001001) sequence: `mem_req` rises in cycle 2. Each instruction takes 4 cycles. `reg_wr` is high exactly in WB. `retired` = 3 after three instructions.
- LW (100011) with 2 wait cycles in both IF and MRD: total 9 cycles. `iord`=1 only in MRD. `reg_wr` is high in WBM.
- BEQ (000100) with `branch_taken`=1, then `branch_taken`=0: `pc_wr`=1 with `pc_src`=01 in the first BR; `pc_wr`=0 in the second. Both count toward `retired`.
- JAL (000011): in JMP, `pc_wr`=1, `pc_src`=10, `reg_wr`=1, `link`=1; back in IF the next cycle.
- Opcode 111111: `illegal` pulses for exactly one cycle in ID, then IF. `retired` is unchanged.
- With `MEM_TIMEOUT`=4, SW (101011) with `mem_ready` held low: after 4 wait cycles, `mem_req` drops, `bus_err`=1, state = HALT. Asserting `rst_n` low clears everything.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: state codes, opcodes,
// PC source selects and the instruction class enum.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_IF    = 4'd1,
    S_ID    = 4'd2,
    S_EX    = 4'd3,
    S_MADDR = 4'd4,
    S_MRD   = 4'd5,
    S_MWR   = 4'd6,
    S_WB    = 4'd7,
    S_WBM   = 4'd8,
    S_BR    = 4'd9,
    S_JMP   = 4'd10,
    S_HALT  = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BR, CLS_J, CLS_JAL, CLS_ILL
  } cls_e;

  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Shared instruction/data memory port between the sequencer and memory.
// Handshake: mem_req is held until the cycle mem_ready is high; that cycle
// completes the access. mem_ready seen while mem_req is low carries no meaning.
interface mc_seq_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_seq_ctrl_op_classify.sv
// Combinational opcode-to-class decode, shared with the main decoder bench.
module op_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output cls_e       cls
);
  always_comb begin
    cls = CLS_ILL;
    unique case (op)
      OP_R:                                   cls = CLS_R;
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:                cls = CLS_ALUI;
      OP_LW, OP_LB, OP_LBU:                   cls = CLS_LOAD;
      OP_SW, OP_SB:                           cls = CLS_STORE;
      OP_REGIMM, OP_BEQ, OP_BNE,
      OP_BLEZ, OP_BGTZ:                       cls = CLS_BR;
      OP_J:                                   cls = CLS_J;
      OP_JAL:                                 cls = CLS_JAL;
      default:                                cls = CLS_ILL;
    endcase
  end
endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle MIPS sequencer: steps IF/ID/EX/MEM/WB over one shared memory
// port, with a per-access wait timeout and a retired-instruction counter.
module mc_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic        branch_taken,
  mc_seq_ctrl_if.master mem,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        reg_wr,
  output logic        link,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retired
);
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_e      r_state;
  logic [15:0] r_wait_cnt;
  logic        r_bus_err;
  logic [31:0] r_retired;

  cls_e w_cls;
  logic w_mem_state;
  logic w_timeout;
  logic w_ready;

  op_classify u_op_classify (.op(op), .cls(w_cls));

  assign w_mem_state = (r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR);
  assign w_timeout   = w_mem_state && (r_wait_cnt == TIMEOUT);
  // ready only completes an access while the request is actually being driven
  assign w_ready     = w_mem_state && !w_timeout && mem.mem_ready;

  assign state   = r_state;
  assign bus_err = r_bus_err;
  assign retired = r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RST;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
      r_retired  <= '0;
    end else begin
      unique case (r_state)
        S_RST: begin
          r_state    <= S_IF;
          r_wait_cnt <= '0;
        end
        S_IF, S_MRD, S_MWR: begin
          if (w_timeout) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else if (w_ready) begin
            r_wait_cnt <= '0;
            unique case (r_state)
              S_IF:    r_state <= S_ID;
              S_MRD:   r_state <= S_WBM;
              default: begin
                r_state   <= S_IF;
                r_retired <= r_retired + 32'd1;
              end
            endcase
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_ID: begin
          r_wait_cnt <= '0;
          unique case (w_cls)
            CLS_R, CLS_ALUI:     r_state <= S_EX;
            CLS_LOAD, CLS_STORE: r_state <= S_MADDR;
            CLS_BR:              r_state <= S_BR;
            CLS_J, CLS_JAL:      r_state <= S_JMP;
            default:             r_state <= S_IF;
          endcase
        end
        S_EX: r_state <= S_WB;
        S_MADDR: begin
          r_wait_cnt <= '0;
          r_state    <= (w_cls == CLS_LOAD) ? S_MRD : S_MWR;
        end
        S_WB, S_WBM, S_BR, S_JMP: begin
          r_state    <= S_IF;
          r_wait_cnt <= '0;
          r_retired  <= r_retired + 32'd1;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = PC_SEQ;
    reg_wr      = 1'b0;
    link        = 1'b0;
    illegal     = 1'b0;
    unique case (r_state)
      S_IF: begin
        mem.mem_req = !w_timeout;
        ir_wr       = w_ready;
        pc_wr       = w_ready;
      end
      S_ID:  illegal = (w_cls == CLS_ILL);
      S_MRD: begin
        mem.mem_req = !w_timeout;
        mem.iord    = 1'b1;
      end
      // the write qualifier drops together with the request on timeout
      S_MWR: begin
        mem.mem_req = !w_timeout;
        mem.mem_we  = !w_timeout;
        mem.iord    = 1'b1;
      end
      S_WB, S_WBM: reg_wr = 1'b1;
      S_BR: begin
        pc_wr  = branch_taken;
        pc_src = PC_BR;
      end
      S_JMP: begin
        pc_wr  = 1'b1;
        pc_src = PC_JMP;
        reg_wr = (w_cls == CLS_JAL);
        link   = (w_cls == CLS_JAL);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: per-scenario tasks with hand-computed
// per-cycle output vectors.
module tb_mc_seq_ctrl;
  localparam logic [3:0] ST_RST = 4'd0, ST_IF = 4'd1, ST_ID = 4'd2, ST_EX = 4'd3,
                         ST_MADDR = 4'd4, ST_MRD = 4'd5, ST_MWR = 4'd6, ST_WB = 4'd7,
                         ST_WBM = 4'd8, ST_BR = 4'd9, ST_JMP = 4'd10, ST_HALT = 4'd11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = 6'd0;
  logic        branch_taken = 1'b0;
  logic        ir_wr, pc_wr, reg_wr, link, illegal, bus_err;
  logic [1:0]  pc_src;
  logic [3:0]  state;
  logic [31:0] retired;
  int          checks = 0;
  int          failures = 0;

  mc_seq_ctrl_if mem_if ();

  mc_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .branch_taken(branch_taken), .mem(mem_if),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr), .link(link),
    .state(state), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, reg_wr, link, illegal}
  wire [13:0] obs = {state, mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_wr, pc_wr,
                     pc_src, reg_wr, link, illegal};

  function automatic logic [13:0] ev(input logic [3:0] s, input logic req, input logic we,
                                     input logic io, input logic ir, input logic pw,
                                     input logic [1:0] src, input logic rw, input logic lk,
                                     input logic il);
    return {s, req, we, io, ir, pw, src, rw, lk, il};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic taken);
    mem_if.mem_ready = rdy;
    branch_taken     = taken;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 1'b0);
    if (obs !== 14'd0) begin $display("FAIL reset_outs: got %h exp %h", obs, 14'd0); failures++; end
    checks++;
    if (retired !== 32'd0) begin $display("FAIL reset_retired: got %0d exp 0", retired); failures++; end
    checks++;
    if (bus_err !== 1'b0) begin $display("FAIL reset_bus_err: got %b exp 0", bus_err); failures++; end
    checks++;
    tick;
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    if (obs !== ev(ST_RST,0,0,0,0,0,2'b00,0,0,0)) begin
      $display("FAIL rst_cycle1: got %h exp %h", obs, ev(ST_RST,0,0,0,0,0,2'b00,0,0,0)); failures++;
    end
    checks++;
    tick;
    drive(1'b1, 1'b0);
    if (obs !== ev(ST_IF,1,0,0,1,1,2'b00,0,0,0)) begin
      $display("FAIL rst_cycle2_if: got %h exp %h", obs, ev(ST_IF,1,0,0,1,1,2'b00,0,0,0)); failures++;
    end
    checks++;
  endtask

  task automatic test_addiu;
    logic [13:0] exp_t[4];
    exp_t[0] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    exp_t[1] = ev(ST_ID,0,0,0,0,0,2'b00,0,0,0);
    exp_t[2] = ev(ST_EX,0,0,0,0,0,2'b00,0,0,0);
    exp_t[3] = ev(ST_WB,0,0,0,0,0,2'b00,1,0,0);
    do_reset;
    op = 6'b001001;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) begin
        tick;
        drive(1'b1, 1'b0);
        if (obs !== exp_t[k]) begin
          $display("FAIL addiu_i%0d_c%0d: got %h exp %h", n, k, obs, exp_t[k]); failures++;
        end
        checks++;
      end
    end
    tick;
    drive(1'b1, 1'b0);
    if (retired !== 32'd3) begin $display("FAIL addiu_retired: got %0d exp 3", retired); failures++; end
    checks++;
  endtask

  task automatic test_lw_wait;
    logic [13:0] exp_t[10];
    logic        rdy_t[10];
    rdy_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t[0] = ev(ST_IF,1,0,0,0,0,2'b00,0,0,0);
    exp_t[1] = ev(ST_IF,1,0,0,0,0,2'b00,0,0,0);
    exp_t[2] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    exp_t[3] = ev(ST_ID,0,0,0,0,0,2'b00,0,0,0);
    exp_t[4] = ev(ST_MADDR,0,0,0,0,0,2'b00,0,0,0);
    exp_t[5] = ev(ST_MRD,1,0,1,0,0,2'b00,0,0,0);
    exp_t[6] = ev(ST_MRD,1,0,1,0,0,2'b00,0,0,0);
    exp_t[7] = ev(ST_MRD,1,0,1,0,0,2'b00,0,0,0);
    exp_t[8] = ev(ST_WBM,0,0,0,0,0,2'b00,1,0,0);
    exp_t[9] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    do_reset;
    op = 6'b100011;
    for (int k = 0; k < 10; k++) begin
      tick;
      drive(rdy_t[k], 1'b0);
      if (obs !== exp_t[k]) begin
        $display("FAIL lw_c%0d: got %h exp %h", k, obs, exp_t[k]); failures++;
      end
      checks++;
    end
    if (retired !== 32'd1) begin $display("FAIL lw_retired: got %0d exp 1", retired); failures++; end
    checks++;
  endtask

  task automatic test_branch;
    logic [13:0] exp_t[7];
    logic        tk_t[7];
    tk_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[0] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    exp_t[1] = ev(ST_ID,0,0,0,0,0,2'b00,0,0,0);
    exp_t[2] = ev(ST_BR,0,0,0,0,1,2'b01,0,0,0);
    exp_t[3] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    exp_t[4] = ev(ST_ID,0,0,0,0,0,2'b00,0,0,0);
    exp_t[5] = ev(ST_BR,0,0,0,0,0,2'b01,0,0,0);
    exp_t[6] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    do_reset;
    op = 6'b000100;
    for (int k = 0; k < 7; k++) begin
      tick;
      drive(1'b1, tk_t[k]);
      if (obs !== exp_t[k]) begin
        $display("FAIL beq_c%0d: got %h exp %h", k, obs, exp_t[k]); failures++;
      end
      checks++;
    end
    if (retired !== 32'd2) begin $display("FAIL beq_retired: got %0d exp 2", retired); failures++; end
    checks++;
  endtask

  task automatic test_jump;
    logic [5:0]  op_t[2];
    logic [13:0] jmp_t[2];
    op_t  = '{6'b000011, 6'b000010};
    jmp_t[0] = ev(ST_JMP,0,0,0,0,1,2'b10,1,1,0);
    jmp_t[1] = ev(ST_JMP,0,0,0,0,1,2'b10,0,0,0);
    do_reset;
    tick;
    for (int n = 0; n < 2; n++) begin
      op = op_t[n];
      drive(1'b1, 1'b0);
      if (obs !== ev(ST_IF,1,0,0,1,1,2'b00,0,0,0)) begin
        $display("FAIL jmp%0d_if: got %h exp %h", n, obs, ev(ST_IF,1,0,0,1,1,2'b00,0,0,0)); failures++;
      end
      checks++;
      tick;
      tick;
      drive(1'b1, 1'b0);
      if (obs !== jmp_t[n]) begin
        $display("FAIL jmp%0d_jmp: got %h exp %h", n, obs, jmp_t[n]); failures++;
      end
      checks++;
      tick;
    end
    drive(1'b1, 1'b0);
    if (state !== ST_IF || retired !== 32'd2) begin
      $display("FAIL jmp_back_if: got state %0d retired %0d exp state 1 retired 2", state, retired); failures++;
    end
    checks++;
  endtask

  task automatic test_illegal;
    logic [5:0] op_t[2];
    op_t = '{6'b111111, 6'b010000};
    do_reset;
    for (int n = 0; n < 2; n++) begin
      op = op_t[n];
      tick;
      drive(1'b1, 1'b0);
      if (obs !== ev(ST_IF,1,0,0,1,1,2'b00,0,0,0)) begin
        $display("FAIL ill%0d_if: got %h exp %h", n, obs, ev(ST_IF,1,0,0,1,1,2'b00,0,0,0)); failures++;
      end
      checks++;
      tick;
      drive(1'b1, 1'b0);
      if (obs !== ev(ST_ID,0,0,0,0,0,2'b00,0,0,1)) begin
        $display("FAIL ill%0d_id: got %h exp %h", n, obs, ev(ST_ID,0,0,0,0,0,2'b00,0,0,1)); failures++;
      end
      checks++;
    end
    tick;
    drive(1'b0, 1'b0);
    if (obs !== ev(ST_IF,1,0,0,0,0,2'b00,0,0,0) || retired !== 32'd0) begin
      $display("FAIL ill_after: got %h retired %0d exp %h retired 0", obs,
               retired, ev(ST_IF,1,0,0,0,0,2'b00,0,0,0)); failures++;
    end
    checks++;
  endtask

  task automatic test_store_timeout;
    logic [13:0] exp_t[4];
    exp_t[0] = ev(ST_IF,1,0,0,1,1,2'b00,0,0,0);
    exp_t[1] = ev(ST_ID,0,0,0,0,0,2'b00,0,0,0);
    exp_t[2] = ev(ST_MADDR,0,0,0,0,0,2'b00,0,0,0);
    exp_t[3] = ev(ST_MWR,1,1,1,0,0,2'b00,0,0,0);
    do_reset;
    op = 6'b101011;
    for (int k = 0; k < 4; k++) begin
      tick;
      drive(1'b1, 1'b0);
      if (obs !== exp_t[k]) begin
        $display("FAIL sw_c%0d: got %h exp %h", k, obs, exp_t[k]); failures++;
      end
      checks++;
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      drive(1'b1, 1'b0);
    end
    if (retired !== 32'd1 || state !== ST_MADDR) begin
      $display("FAIL sw_retired: got retired %0d state %0d exp 1 state 4", retired, state); failures++;
    end
    checks++;
    for (int k = 0; k < 4; k++) begin
      tick;
      drive(1'b0, 1'b0);
      if (obs !== exp_t[3]) begin
        $display("FAIL sw_wait%0d: got %h exp %h", k, obs, exp_t[3]); failures++;
      end
      checks++;
    end
    tick;
    drive(1'b1, 1'b0);
    if ({state, mem_if.mem_req} !== {ST_MWR, 1'b0}) begin
      $display("FAIL sw_timeout_req: got state %0d req %b exp state 6 req 0", state, mem_if.mem_req); failures++;
    end
    checks++;
    for (int k = 0; k < 2; k++) begin
      tick;
      drive(1'b1, 1'b0);
      if (obs !== ev(ST_HALT,0,0,0,0,0,2'b00,0,0,0) || bus_err !== 1'b1 || retired !== 32'd1) begin
        $display("FAIL sw_halt%0d: got %h bus_err %b retired %0d exp %h bus_err 1 retired 1", k,
                 obs, bus_err, retired, ev(ST_HALT,0,0,0,0,0,2'b00,0,0,0)); failures++;
      end
      checks++;
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0);
    if (obs !== 14'd0 || bus_err !== 1'b0 || retired !== 32'd0) begin
      $display("FAIL sw_reset_clear: got %h bus_err %b retired %0d exp 0", obs, bus_err, retired); failures++;
    end
    checks++;
  endtask

  task automatic test_async_drop;
    do_reset;
    op = 6'b001001;
    tick;
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    if (mem_if.mem_req !== 1'b0 || state !== ST_RST) begin
      $display("FAIL async_drop: got req %b state %0d exp req 0 state 0", mem_if.mem_req, state); failures++;
    end
    checks++;
  endtask

  initial begin
    mem_if.mem_ready = 1'b0;
    test_reset;
    test_addiu;
    test_lw_wait;
    test_branch;
    test_jump;
    test_illegal;
    test_store_timeout;
    test_async_drop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
